wide_add_sequencer: RTL

- Multi-cycle controller that performs 16*WORDS-bit add/subtract by sequencing operands through one external 16-bit combinational adder, least-significant chunk first.
- Acts as that adder's upstream feeder: drives its A/B/Cin. Acts as its downstream consumer: registers its Sum/Cout.
- The adder stays outside this block, so the parent can plug in any 16-bit adder architecture (ripple, lookahead, select, ...) with identical port semantics.

---
 rtl/wide_add_sequencer_pkg.sv | 26 ++
 rtl/wide_add_sequencer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/wide_add_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// wide_add_sequencer_pkg
//   Shared definitions for multi-cycle arithmetic blocks that walk wide
//   operands through a narrow external datapath one chunk at a time.
//
//   CHUNK_W  : width of one chunk handled by the external adder per cycle.
//   state_t  : sequencer control states (IDLE, RUN, DONE).
//   flags_t  : status bundle reported alongside a completed result.
// -----------------------------------------------------------------------------
package wide_add_sequencer_pkg;

  localparam int CHUNK_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic carry_out;  // final carry; after a subtract, 1 means no borrow
    logic overflow;   // signed two's-complement overflow
    logic zero;       // complete result is all zeros
  } flags_t;

endpackage : wide_add_sequencer_pkg

// File: rtl/wide_add_sequencer.sv
// -----------------------------------------------------------------------------
// wide_add_sequencer
//   Performs a (CHUNK_W*WORDS)-bit add or subtract by feeding one chunk per
//   cycle, least-significant first, through an external combinational
//   CHUNK_W-bit adder and registering what comes back. The adder itself lives
//   in the parent so any adder architecture with the same ports can be used.
//
// Ports
//   Clk, Rst             : rising-edge clock, asynchronous active-high reset
//   InValid / InReady    : request handshake (OpA, OpB, Sub sampled on accept)
//   OpA, OpB             : operands, CHUNK_W*WORDS bits
//   Sub                  : 0 -> OpA + OpB, 1 -> OpA - OpB
//   OutValid / OutReady  : result handshake; outputs held while OutReady = 0
//   Result               : sum / difference
//   CarryOut, Overflow,
//   Zero                 : status flags of the completed operation
//   AdderA/B/Cin         : drive the external adder (zero outside RUN)
//   AdderSum/AdderCout   : returned from the external adder
// -----------------------------------------------------------------------------
module wide_add_sequencer
  import wide_add_sequencer_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                       Clk,
  input  logic                       Rst,
  input  logic                       InValid,
  output logic                       InReady,
  input  logic [CHUNK_W*WORDS-1:0]   OpA,
  input  logic [CHUNK_W*WORDS-1:0]   OpB,
  input  logic                       Sub,
  output logic                       OutValid,
  input  logic                       OutReady,
  output logic [CHUNK_W*WORDS-1:0]   Result,
  output logic                       CarryOut,
  output logic                       Overflow,
  output logic                       Zero,
  output logic [CHUNK_W-1:0]         AdderA,
  output logic [CHUNK_W-1:0]         AdderB,
  output logic                       AdderCin,
  input  logic [CHUNK_W-1:0]         AdderSum,
  input  logic                       AdderCout
);

  localparam int W     = CHUNK_W * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  state_t           r_state;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;          // OpB already inverted for subtract
  logic             r_sub;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic [W-1:0]     r_result;
  flags_t           r_flags;
  logic             r_out_valid;

  logic [CHUNK_W-1:0] w_chunk_a;
  logic [CHUNK_W-1:0] w_chunk_b;
  logic [W-1:0]       w_next_result;
  logic               w_last;
  flags_t             w_flags;

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    w_chunk_a     = r_a[int'(r_idx)*CHUNK_W +: CHUNK_W];
    w_chunk_b     = r_b[int'(r_idx)*CHUNK_W +: CHUNK_W];
    w_last        = (r_idx == LAST_IDX);

    // Result as it will look after this cycle's chunk is written; on the last
    // chunk this is the complete value, so Zero can be registered together
    // with it instead of a cycle later.
    w_next_result = r_result;
    w_next_result[int'(r_idx)*CHUNK_W +: CHUNK_W] = AdderSum;

    // Overflow: operands share a sign (B taken after inversion) and the top
    // sum bit disagrees with it.
    w_flags.carry_out = AdderCout;
    w_flags.overflow  = (r_a[W-1] == r_b[W-1]) &&
                        (AdderSum[CHUNK_W-1] != r_a[W-1]);
    w_flags.zero      = (w_next_result == '0);
  end

  // The external adder sees zeros unless a chunk is actually in flight.
  always_comb begin
    AdderA   = '0;
    AdderB   = '0;
    AdderCin = 1'b0;
    if (r_state == RUN) begin
      AdderA   = w_chunk_a;
      AdderB   = w_chunk_b;
      // Subtract is A + ~B + 1: the +1 enters as carry-in of chunk 0.
      AdderCin = (r_idx == '0) ? r_sub : r_carry;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_sub       <= 1'b0;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (InValid && InReady) begin
            r_a      <= OpA;
            r_b      <= OpB ^ {W{Sub}};
            r_sub    <= Sub;
            r_idx    <= '0;
            r_carry  <= 1'b0;
            // Clear so a partially built result never shows stale chunks.
            r_result <= '0;
            r_flags  <= '0;
            r_state  <= RUN;
          end
        end

        RUN: begin
          r_result <= w_next_result;
          r_carry  <= AdderCout;
          if (w_last) begin
            r_idx       <= '0;
            r_flags     <= w_flags;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end

        DONE: begin
          if (OutReady) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end

        default: begin
          r_out_valid <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  // Ready is gated by Rst so it drops the moment reset is applied.
  assign InReady  = (r_state == IDLE) && !Rst;
  assign OutValid = r_out_valid;
  assign Result   = r_result;
  assign CarryOut = r_flags.carry_out;
  assign Overflow = r_flags.overflow;
  assign Zero     = r_flags.zero;

endmodule : wide_add_sequencer
